mem_responder: RTL and testbench

Multi-cycle memory responder serving the multicycle CPU controller's memory strobes (MemRead, MemWrite, with the address chosen by IorD). It sits between the CPU datapath and a word-organised internal RAM. It latches each request, inserts a configurable number of wait states, performs the read or write, and pulses `ready` when data is valid or the write has committed. It is the memory end of the interface the controller drives.

---
 rtl/mem_responder_if.sv | 39 +++
 rtl/mem_responder.sv | 151 +++++++++++++++
 tb/tb_mem_responder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Bus between the multicycle CPU controller (master) and mem_responder (slave).
// Carries the level-sensitive read/write strobes, byte address and write data
// toward the memory, and the registered read data plus status back to the CPU.
interface mem_responder_if;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    // CPU side: drives strobes, address and write data.
    modport master (
        output mem_read,
        output mem_write,
        output addr,
        output wdata,
        input  rdata,
        input  ready,
        input  busy,
        input  err
    );

    // Memory side: samples the request, returns data and status.
    modport slave (
        input  mem_read,
        input  mem_write,
        input  addr,
        input  wdata,
        output rdata,
        output ready,
        output busy,
        output err
    );

endinterface

// File: rtl/mem_responder.sv
// Multi-cycle memory responder for the multicycle CPU controller.
// Latches a request from IDLE, spends WAIT_CYCLES wait states in WAIT, performs
// the RAM access in a single ACCESS cycle, then pulses ready in DONE.
// A write held across many cycles commits only once (wr_done); a held read
// re-triggers on every return to IDLE.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject requests whose latched
// addr[1:0] is non-zero (no RAM write, rdata loaded with 0, err pulsed with ready).
module mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_responder_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    localparam int         DEPTH     = 1 << ADDR_W;
    // Counter value on WAIT entry; unused when there are no wait states.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        is_wr_q, is_wr_d;
    logic        wr_done_q, wr_done_d;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic              wr_eligible;
    logic              accept;
    logic              misaligned;
    logic              ram_we;
    logic              unused_addr_bits;

    // Word index wraps modulo the RAM depth; upper and byte-lane bits are dropped.
    assign word_idx         = addr_q[ADDR_W+1:2];
    assign unused_addr_bits = ^{addr_q[31:ADDR_W+2], addr_q[1:0]};

    // A write is only eligible once per continuous mem_write assertion.
    assign wr_eligible = bus.mem_write && !wr_done_q;
    assign accept      = wr_eligible || bus.mem_read;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (addr_q[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign ram_we = (state_q == S_ACCESS) && is_wr_q && !misaligned;

    // State register; reset aborts any access in flight.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE -> WAIT (or straight to ACCESS) -> ACCESS -> DONE -> IDLE.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
            S_WAIT:   if (cnt_q == 4'd0) state_d = S_ACCESS;
            S_ACCESS: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Request latch, wait counter, read-data capture and write-once tracking.
    always_comb begin
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        is_wr_d   = is_wr_q;
        wr_done_d = wr_done_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    is_wr_d = wr_eligible;
                    cnt_d   = WAIT_LOAD;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            end
            S_ACCESS: begin
                // A rejected write still counts as done so a held strobe does not retry.
                if (is_wr_q) wr_done_d = 1'b1;
                if (misaligned) begin
                    rdata_d = 32'd0;
                end else if (!is_wr_q) begin
                    rdata_d = mem[word_idx];
                end
            end
            default: ;
        endcase
        // Dropping mem_write re-arms the next write.
        if (!bus.mem_write) wr_done_d = 1'b0;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 4'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            is_wr_q   <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            is_wr_q   <= is_wr_d;
            wr_done_q <= wr_done_d;
        end
    end

    // RAM write port; an aborted write never reaches ACCESS so it never commits.
    // NOTE: the RAM array is deliberately not reset so it maps onto plain memory macros.
    always_ff @(posedge clk) begin
        if (ram_we) mem[word_idx] <= wdata_q;
    end

    // Outputs decoded from the state register.
    always_comb begin
        bus.rdata = rdata_q;
        bus.ready = (state_q == S_DONE);
        bus.busy  = (state_q != S_IDLE);
        bus.err   = (state_q == S_DONE) && misaligned;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder (ADDR_W=10, WAIT_CYCLES=2).
// A transaction-level model (cycle index since acceptance, flat memory array)
// predicts busy/ready/rdata/err and is compared on every falling edge; directed
// scenarios add literal expectations for latency, data and pulse counts.
module tb_mem_responder;

    localparam int ADDR_W = 10;
    localparam int W      = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    bit   cmp_en   = 1'b0;

    mem_responder_if bus ();

    mem_responder #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [DEPTH];
    int          phase     = 0;   // 0 = idle, k = k-th cycle after acceptance
    bit          m_wr_done = 1'b0;
    bit          m_wr      = 1'b0;
    bit          m_mis     = 1'b0;
    logic [31:0] m_rdata   = 32'd0;
    logic [31:0] m_addr    = 32'd0;
    logic [31:0] m_wdata   = 32'd0;

    task automatic model_commit();
        int idx;
        idx = int'((m_addr >> 2) % DEPTH);
        if (m_mis)      m_rdata = 32'd0;
        else if (m_wr)  m_mem[idx] = m_wdata;
        else            m_rdata = m_mem[idx];
        if (m_wr) m_wr_done = 1'b1;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            phase     = 0;
            m_wr_done = 1'b0;
            m_rdata   = 32'd0;
            m_mis     = 1'b0;
        end else begin
            if (phase == W + 2) begin
                phase = 0;
            end else if (phase > 0) begin
                phase++;
                if (phase == W + 2) model_commit();
            end else if ((bus.mem_write && !m_wr_done) || bus.mem_read) begin
                m_wr    = bus.mem_write && !m_wr_done;
                m_addr  = bus.addr;
                m_wdata = bus.wdata;
`ifdef MEM_ALIGN_CHECK_EN
                m_mis   = (bus.addr[1:0] != 2'b00);
`else
                m_mis   = 1'b0;
`endif
                phase   = 1;
            end
            if (!bus.mem_write) m_wr_done = 1'b0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_busy",  32'(bus.busy),  32'(phase != 0));
            check("cmp_ready", 32'(bus.ready), 32'(phase == W + 2));
            check("cmp_err",   32'(bus.err),   32'((phase == W + 2) && m_mis));
            check("cmp_rdata", bus.rdata,      m_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] data, output int cycles, output logic err);
        bit seen;
        seen   = 1'b0;
        cycles = -1;
        data   = 32'd0;
        err    = 1'b0;
        @(posedge clk); #1;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.addr      = a;
        bus.wdata     = d;
        // Negedge index 0 is the IDLE cycle that ends with the acceptance edge.
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.ready) begin
                seen   = 1'b1;
                cycles = k;
                data   = bus.rdata;
                err    = bus.err;
                break;
            end
        end
        check("ready_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        logic [31:0] data;
        int          cyc;
        logic        err;
        int          pulses;
        int          last;
        int          first;

        rst_n         = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.addr      = 32'd0;
        bus.wdata     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_rdata", bus.rdata,      32'd0);
        check("rst_err",   32'(bus.err),   32'd0);
        @(negedge clk); #2;
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Write then read.
        access(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, data, cyc, err);
        check("wr_latency", 32'(cyc), 32'd4);
        access(1'b1, 1'b0, 32'h40, 32'h0, data, cyc, err);
        check("rd_latency", 32'(cyc), 32'd4);
        check("rd_data", data, 32'hDEADBEEF);

        // Held write: one commit, later wdata change ignored.
        @(posedge clk); #1;
        bus.mem_write = 1'b1;
        bus.addr      = 32'h80;
        bus.wdata     = 32'h11;
        pulses        = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 10) bus.wdata = 32'h22;
            if (bus.ready) pulses++;
        end
        check("held_wr_pulses", 32'(pulses), 32'd1);
        @(posedge clk); #1;
        bus.mem_write = 1'b0;
        access(1'b1, 1'b0, 32'h80, 32'h0, data, cyc, err);
        check("held_wr_data", data, 32'h11);

        // Held read: ready every 5 cycles, data constant.
        @(posedge clk); #1;
        bus.mem_read = 1'b1;
        bus.addr     = 32'h80;
        pulses       = 0;
        last         = -1;
        first        = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                pulses++;
                if (last >= 0) check("held_rd_gap", 32'(i - last), 32'd5);
                else           first = i;
                last = i;
                check("held_rd_data", bus.rdata, 32'h11);
            end
        end
        check("held_rd_first", 32'(first), 32'd4);
        check("held_rd_pulses", 32'(pulses), 32'd4);
        @(posedge clk); #1;
        bus.mem_read = 1'b0;

        // Simultaneous strobes: write wins, rdata keeps the last read value.
        access(1'b1, 1'b1, 32'h8, 32'h5A5A5A5A, data, cyc, err);
        check("simul_rdata_kept", data, 32'h11);
        access(1'b1, 1'b0, 32'h8, 32'h0, data, cyc, err);
        check("simul_readback", data, 32'h5A5A5A5A);

        // Reset during WAIT of a write aborts it.
        access(1'b0, 1'b1, 32'h10, 32'h33, data, cyc, err);
        access(1'b1, 1'b0, 32'h10, 32'h0, data, cyc, err);
        check("pre_rst_data", data, 32'h33);
        @(posedge clk); #1;
        bus.mem_write = 1'b1;
        bus.addr      = 32'h10;
        bus.wdata     = 32'h77;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  32'(bus.busy),  32'd0);
        check("mid_rst_ready", 32'(bus.ready), 32'd0);
        check("mid_rst_rdata", bus.rdata,      32'd0);
        bus.mem_write = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
        access(1'b1, 1'b0, 32'h10, 32'h0, data, cyc, err);
        check("post_rst_data", data, 32'h33);

        // Address wrap modulo 1024 words.
        access(1'b0, 1'b1, 32'h1000, 32'hCAFEF00D, data, cyc, err);
        access(1'b1, 1'b0, 32'h0, 32'h0, data, cyc, err);
        check("wrap_data", data, 32'hCAFEF00D);

        // Misaligned read.
        access(1'b1, 1'b0, 32'h2, 32'h0, data, cyc, err);
        check("misalign_latency", 32'(cyc), 32'd4);
`ifdef MEM_ALIGN_CHECK_EN
        check("misalign_err",   32'(err), 32'd1);
        check("misalign_rdata", data,     32'd0);
`else
        check("misalign_err",   32'(err), 32'd0);
        check("misalign_rdata", data,     32'hCAFEF00D);
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
